instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the single-issue RISC-V core. It owns the PC and issues one-outstanding-request reads to instruction memory over a req/gnt/rvalid handshake. Each returned word is buffered and handed to decode (opcode to `control_unit`, full word to the register/immediate decoders) over a valid/ready handshake. Branch/jump redirects flush buffered and in-flight instructions.

## Interface
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  XLEN  word address of the request; bits [1:0] are always 0.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  XLEN  instruction word.
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode accepts the instruction this cycle.
- `if_instr`  out  XLEN  buffered instruction.
- `if_pc`  out  XLEN  PC of `if_instr`.
- `if_opcode`  out  7  `if_instr[6:0]`, the opcode fed to `control_unit`.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
- `if_fetch_cnt`  out  32  instructions delivered. Present only with `IFU_PERF_CNT_EN`.

## Operation
- FSM states: FETCH, WAIT, HOLD, DRAIN.
  - FETCH: `imem_req`=1, `imem_addr`=pc. On `imem_gnt`, go to WAIT.
  - WAIT: on `imem_rvalid`, capture `imem_rdata`/pc into the buffer, set pc += 4, go to HOLD.
  - HOLD: `if_valid`=1. On `if_ready`, the buffer is consumed and the FSM goes to FETCH; `imem_req` is asserted the following cycle.
  - DRAIN: one granted request is still outstanding. The next `imem_rvalid` is discarded, then go to FETCH.
- `imem_req`/`imem_addr` stay stable from assertion until `imem_gnt`; no request is withdrawn except by redirect.
- At most one request is outstanding.
- `if_instr`, `if_pc` and `if_opcode` are stable while `if_valid`=1 and `if_ready`=0.
- PC arithmetic is modulo 2^XLEN: pc = 32'hFFFF_FFFC increments to 32'h0000_0000 with no error.
- Redirect has priority over every other event in the same cycle:
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - The buffer is invalidated, so `if_valid`=0 next cycle even if `if_ready` was high.
  - From FETCH without gnt, or from HOLD: go to FETCH at the new pc next cycle.
  - From FETCH with `imem_gnt`=1 the same cycle, or from WAIT without `imem_rvalid`: go to DRAIN.
  - From WAIT with `imem_rvalid`=1 the same cycle: the data is dropped and the FSM goes to FETCH.
  - In DRAIN: the target pc is updated and the FSM stays in DRAIN.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `if_valid`=0, `if_instr`=32'h0000_0013 (NOP), `if_opcode`=7'b0010011, `if_pc`=RESET_PC, pc=RESET_PC, FSM=FETCH, counter=0.
- First `imem_req`=1 in the first cycle after `rst_n` deasserts.
- Latency: gnt in cycle N, rvalid in cycle M ≥ N+1, `if_valid`=1 in cycle M+1.
- Peak throughput: one instruction per 3 cycles (gnt, rvalid, handoff).
- Reset asserted mid-operation: all state returns to reset values at the next edge. A late `imem_rvalid` after reset with no granted request is ignored.
- `imem_rvalid` arriving outside WAIT/DRAIN is ignored.

## Configuration
- `IFU_PERF_CNT_EN` defined: the `if_fetch_cnt` port exists.
  - The counter increments by 1 on each `if_valid && if_ready && !redirect_valid` cycle.
  - It wraps from 32'hFFFF_FFFF to 0 and resets to 0.
- `IFU_PERF_CNT_EN` undefined: no port, no counter logic; all other behaviour is identical.

## Test plan
- Reset release, memory returns 32'h0000_0033 with gnt/rvalid one cycle apart, `if_ready`=1 -> `imem_addr`=0, then 4, 8; `if_opcode`=7'b0110011; `if_pc`=0, 4, 8.
- `imem_gnt` withheld 5 cycles -> `imem_req`/`imem_addr`=0 held stable for all 6 cycles; no second request.
- `if_ready`=0 for 4 cycles with `if_valid`=1, then `if_ready`=1 -> `if_instr` and `if_pc` unchanged throughout; the next `imem_req` is asserted one cycle after the handoff.
- Redirect to 32'h0000_0102 while in WAIT -> the next rvalid (word 32'h0000_0063) never appears on `if_valid`; next `imem_addr`=32'h0000_0100.
- Redirect in the same cycle as `if_valid && if_ready` -> `if_fetch_cnt` not incremented (with `IFU_PERF_CNT_EN`); `if_valid`=0 next cycle.
- RESET_PC=32'hFFFF_FFFC -> the second `imem_addr` is 32'h0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem read outstanding and holds one word for decode.
// Defining IFU_PERF_CNT_EN adds the if_fetch_cnt port, which counts delivered instructions.
module instr_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [6:0]      if_opcode,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]     if_fetch_cnt
`endif
);

   localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t          state_r;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] instr_r;
   logic [XLEN-1:0] ipc_r;
   logic            req_r;
   logic            valid_r;

   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] pc_inc_s;
   logic            unused_s;

   assign target_s  = {redirect_pc[XLEN-1:2], 2'b00};
   assign pc_inc_s  = pc_r + PC_STEP;
   assign unused_s  = ^redirect_pc[1:0];

   assign imem_req  = req_r;
   assign imem_addr = pc_r;
   assign if_valid  = valid_r;
   assign if_instr  = instr_r;
   assign if_pc     = ipc_r;
   assign if_opcode = instr_r[6:0];

   // Fetch FSM; req/valid are registered alongside the state so they reflect it directly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= FETCH;
         pc_r    <= RESET_PC;
         instr_r <= NOP_INSTR;
         ipc_r   <= RESET_PC;
         req_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         case (state_r)
            FETCH: begin
               // A grant only counts while the request is actually on the bus.
               if (redirect_valid) begin
                  pc_r    <= target_s;
                  valid_r <= 1'b0;
                  if (req_r && imem_gnt) begin
                     state_r <= DRAIN;
                     req_r   <= 1'b0;
                  end else begin
                     state_r <= FETCH;
                     req_r   <= 1'b1;
                  end
               end else if (req_r && imem_gnt) begin
                  state_r <= WAIT;
                  req_r   <= 1'b0;
               end else begin
                  state_r <= FETCH;
                  req_r   <= 1'b1;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  pc_r    <= target_s;
                  valid_r <= 1'b0;
                  if (imem_rvalid) begin
                     state_r <= FETCH;
                     req_r   <= 1'b1;
                  end else begin
                     state_r <= DRAIN;
                     req_r   <= 1'b0;
                  end
               end else if (imem_rvalid) begin
                  instr_r <= imem_rdata;
                  ipc_r   <= pc_r;
                  pc_r    <= pc_inc_s;
                  valid_r <= 1'b1;
                  state_r <= HOLD;
               end else begin
                  state_r <= WAIT;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  pc_r    <= target_s;
                  valid_r <= 1'b0;
                  state_r <= FETCH;
                  req_r   <= 1'b1;
               end else if (if_ready) begin
                  valid_r <= 1'b0;
                  state_r <= FETCH;
                  req_r   <= 1'b1;
               end else begin
                  state_r <= HOLD;
               end
            end
            DRAIN: begin
               // The stale response retires the old request even if a new redirect lands with it.
               if (redirect_valid) begin
                  pc_r <= target_s;
               end else begin
                  pc_r <= pc_r;
               end
               if (imem_rvalid) begin
                  state_r <= FETCH;
                  req_r   <= 1'b1;
               end else begin
                  state_r <= DRAIN;
               end
            end
            default: begin
               state_r <= FETCH;
               req_r   <= 1'b0;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_r;

   // Counts handoffs accepted by decode; a same-cycle redirect cancels the handoff.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_r <= 32'd0;
      end else if (valid_r && if_ready && !redirect_valid) begin
         fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
         fetch_cnt_r <= fetch_cnt_r;
      end
   end

   assign if_fetch_cnt = fetch_cnt_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed handshake scenarios, then randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_gnt, imem_rvalid, if_ready, redirect_valid;
   logic [31:0] imem_rdata, redirect_pc;
   logic        imem_req, if_valid;
   logic [31:0] imem_addr, if_instr, if_pc;
   logic [6:0]  if_opcode;
   logic        req2, valid2;
   logic [31:0] addr2, instr2, pc2;
   logic [6:0]  opcode2;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] if_fetch_cnt, cnt2;
`endif

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Model: next fetch address, outstanding-request bookkeeping and a one-word buffer.
   logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
   bit          m_buf, m_out, m_stale, m_started;

   always #5 clk = ~clk;

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
      .if_pc(if_pc), .if_opcode(if_opcode),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_CNT_EN
      , .if_fetch_cnt(if_fetch_cnt)
`endif
   );

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .imem_req(req2), .imem_addr(addr2), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(valid2), .if_ready(if_ready), .if_instr(instr2),
      .if_pc(pc2), .if_opcode(opcode2),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_CNT_EN
      , .if_fetch_cnt(cnt2)
`endif
   );

   function automatic bit exp_req();
      return m_started && !m_out && !m_buf;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit req_now;
      if (!rst_n) begin
         m_pc = 32'h0000_0000; m_instr = 32'h0000_0013; m_ipc = 32'h0000_0000;
         m_cnt = 32'd0; m_buf = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_started = 1'b0;
      end else begin
         req_now   = exp_req();
         m_started = 1'b1;
         if (redirect_valid) begin
            m_pc  = {redirect_pc[31:2], 2'b00};
            m_buf = 1'b0;
            if (req_now && imem_gnt) begin
               m_out = 1'b1; m_stale = 1'b1;
            end else if (m_out && imem_rvalid) begin
               m_out = 1'b0;
            end else if (m_out) begin
               m_stale = 1'b1;
            end
         end else begin
            if (m_buf && if_ready) begin
               m_buf = 1'b0;
               m_cnt = m_cnt + 32'd1;
            end
            if (req_now && imem_gnt) begin
               m_out = 1'b1; m_stale = 1'b0;
            end else if (m_out && imem_rvalid) begin
               m_out = 1'b0;
               if (!m_stale) begin
                  m_buf = 1'b1; m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
               end
            end
         end
      end
   endtask

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", 32'(imem_req), 32'(exp_req()));
         if (exp_req() || !m_started) chk("imem_addr", imem_addr, m_pc);
         chk("if_valid", 32'(if_valid), 32'(m_buf));
         if (m_buf || !m_started) begin
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", if_pc, m_ipc);
            chk("if_opcode", 32'(if_opcode), 32'(m_instr[6:0]));
         end
`ifdef IFU_PERF_CNT_EN
         chk("if_fetch_cnt", if_fetch_cnt, m_cnt);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;
   endtask

   task automatic fetch_one(input logic [31:0] word, input int gd, input int rd, input int hd,
                            input logic [31:0] a);
      chk("dir_req", 32'(imem_req), 32'd1);
      chk("dir_addr", imem_addr, a);
      for (int i = 0; i < gd; i++) begin
         tick();
         chk("stall_req", 32'(imem_req), 32'd1);
         chk("stall_addr", imem_addr, a);
      end
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      chk("one_outstanding", 32'(imem_req), 32'd0);
      for (int i = 0; i < rd; i++) begin
         tick();
         chk("wait_valid", 32'(if_valid), 32'd0);
      end
      imem_rvalid = 1'b1; imem_rdata = word; tick(); imem_rvalid = 1'b0;
      chk("dir_valid", 32'(if_valid), 32'd1);
      chk("dir_instr", if_instr, word);
      chk("dir_pc", if_pc, a);
      chk("dir_opcode", 32'(if_opcode), 32'(word[6:0]));
      for (int i = 0; i < hd; i++) begin
         tick();
         chk("stall_valid", 32'(if_valid), 32'd1);
         chk("stall_instr", if_instr, word);
         chk("stall_pc", if_pc, a);
      end
      if_ready = 1'b1; tick(); if_ready = 1'b0;
      chk("handoff_valid", 32'(if_valid), 32'd0);
      chk("next_req", 32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, a + 32'd4);
   endtask

   task automatic rand_inputs();
      imem_gnt       = exp_req() && ($urandom_range(0, 2) != 0);
      imem_rvalid    = m_out ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      imem_rdata     = $urandom;
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      rst_n          = ($urandom_range(0, 499) != 0);
   endtask

   initial begin
      logic [31:0] a;
      rst_n = 1'b0;
      idle();
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0000_0000);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_instr", if_instr, 32'h0000_0013);
      chk("rst_opcode", 32'(if_opcode), 32'h0000_0013);
      chk("rst_addr2", addr2, 32'hFFFF_FFFC);

      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         a = 32'(i) * 32'd4;
         chk("addr_wrap2", addr2, 32'hFFFF_FFFC + a);
         fetch_one(32'h0000_0033, 0, 0, 0, a);
         chk("opcode_r", {25'd0, if_opcode}, 32'h0000_0033);
      end
      fetch_one(32'h0000_0013, 5, 2, 0, 32'h0000_000C);
      fetch_one(32'h00A0_0093, 0, 0, 4, 32'h0000_0010);

      // Redirect while the read is in flight: the returning word must be dropped.
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; tick(); redirect_valid = 1'b0;
      chk("drain_req", 32'(imem_req), 32'd0);
      tick();
      chk("drain_req2", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0063; tick(); imem_rvalid = 1'b0;
      chk("drop_valid", 32'(if_valid), 32'd0);
      chk("redir_req", 32'(imem_req), 32'd1);
      chk("redir_addr", imem_addr, 32'h0000_0100);
      tick();
      chk("drop_valid2", 32'(if_valid), 32'd0);

      // Redirect in the same cycle as a handoff.
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; tick(); imem_rvalid = 1'b0;
      chk("hold_pc", if_pc, 32'h0000_0100);
      if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; tick();
      if_ready = 1'b0; redirect_valid = 1'b0;
      chk("cancel_valid", 32'(if_valid), 32'd0);
      chk("cancel_addr", imem_addr, 32'h0000_0200);
`ifdef IFU_PERF_CNT_EN
      chk("cnt_cancel", if_fetch_cnt, 32'd5);
`endif

      // Reset with a read in flight, then a late response.
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0063; tick(); imem_rvalid = 1'b0;
      chk("late_valid", 32'(if_valid), 32'd0);
      chk("late_addr", imem_addr, 32'h0000_0000);

      for (int c = 0; c < 4000; c++) begin
         rand_inputs();
         tick();
      end
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
